// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory and decode handshake bundle for the fetch stage
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch;
    logic        zero;
    logic [31:0] branch_offset;

    modport master (
        output imem_req, imem_addr, instr, opcode, pc, pc_plus4, instr_valid,
        input  imem_rdata, imem_ack, instr_ready, branch, zero, branch_offset
    );

    modport slave (
        input  imem_req, imem_addr, instr, opcode, pc, pc_plus4, instr_valid,
        output imem_rdata, imem_ack, instr_ready, branch, zero, branch_offset
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - MIPS-lite fetch stage: owns the PC, fetches over req/ack, hands words to decode
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        req_q, req_d;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;

    assign pc_plus4      = pc_q + 32'd4;
    assign branch_target = pc_plus4 + {bus.branch_offset[29:0], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            req_q   <= req_d;
        end
    end

    // imem_ack only matters in FETCH, where req_q is guaranteed high; acks elsewhere fall through.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        req_d   = req_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                req_d   = 1'b1;
            end
            FETCH: begin
                if (bus.imem_ack) begin
                    instr_d = bus.imem_rdata;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.instr_ready) begin
                    pc_d    = (bus.branch && bus.zero) ? branch_target : pc_plus4;
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                req_d   = 1'b0;
            end
        endcase
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.opcode      = instr_q[31:26];
    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with randomized memory, stalls and branches
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rst2_n;

    fetch_unit_if b();
    fetch_unit_if b2();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut  (.clk(clk), .rst_n(rst_n),  .bus(b));
    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (.clk(clk), .rst_n(rst2_n), .bus(b2));

    int tests = 0;
    int fails = 0;
    int consumed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h8C01_0004;
        if (a == 32'h4) return 32'h0022_1820;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // Reference model: the sequence of PCs decode should see, one entry per instruction.
    logic [31:0] exp_q[$];
    logic [31:0] cur_pc;

    // Instruction memory responder
    int  mem_wait = 0;
    bit  mem_rand = 0;
    bit  stray_en = 0;
    bit  rst_ack  = 0;
    initial begin : responder
        int wcnt;
        int target;
        bit busy;
        wcnt = 0; target = 0; busy = 0;
        b.imem_ack = 1'b0;
        b.imem_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                wcnt = 0; busy = 0;
                b.imem_ack = rst_ack;
                b.imem_rdata = 32'hDEAD_BEEF;
            end else if (b.imem_req) begin
                if (!busy) begin
                    busy = 1;
                    target = mem_rand ? int'($urandom_range(0, 3)) : mem_wait;
                end
                if (wcnt >= target) begin
                    b.imem_ack = 1'b1;
                    b.imem_rdata = mem_word(b.imem_addr);
                    wcnt = 0; busy = 0;
                end else begin
                    b.imem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                wcnt = 0; busy = 0;
                b.imem_ack = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
                b.imem_rdata = $urandom;
            end
        end
    end

    // Decode-side driver: chooses ready and branch inputs, advances the reference PC on consume.
    int          ready_mode = 1;
    bit          rand_br = 0;
    bit          dir_en = 0;
    logic [31:0] dir_pc = 32'h0;
    logic [31:0] dir_off = 32'h0;
    bit          dir_zero = 0;
    initial begin : decode_drv
        logic        br, zr, tk;
        logic [31:0] off, nxt;
        int          o;
        b.instr_ready = 1'b0;
        b.branch = 1'b0;
        b.zero = 1'b0;
        b.branch_offset = 32'h0;
        forever begin
            @(posedge clk); #1;
            b.instr_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
            if (rst_n && b.instr_valid && b.instr_ready) begin
                if (dir_en && cur_pc == dir_pc) begin
                    br = 1'b1; zr = dir_zero; off = dir_off;
                end else if (rand_br) begin
                    br = 1'($urandom_range(0, 1));
                    zr = 1'($urandom_range(0, 1));
                    o = int'($urandom_range(0, 32)) - 16;
                    off = ($urandom_range(0, 3) == 0) ? $urandom : 32'(o);
                end else begin
                    br = 1'($urandom_range(0, 1)); zr = 1'b0; off = $urandom;
                end
                tk = br & zr;
                nxt = cur_pc + 32'd4 + (tk ? off * 32'd4 : 32'd0);
                cur_pc = nxt;
                exp_q.push_back(nxt);
            end else begin
                br = 1'($urandom_range(0, 1));
                zr = 1'($urandom_range(0, 1));
                off = $urandom;
            end
            b.branch = br;
            b.zero = zr;
            b.branch_offset = off;
        end
    end

    // Monitor: checks every accepted fetch address and every consumed instruction.
    initial begin : monitor
        bit          pend_valid;
        logic [31:0] p, w;
        pend_valid = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (pend_valid) begin
                    chk("valid_after_ack", {31'b0, b.instr_valid}, 32'd1);
                    pend_valid = 0;
                end
                if (b.imem_req && b.imem_ack) begin
                    if (exp_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL fetch_addr: got %h expected none", b.imem_addr);
                    end else begin
                        chk("fetch_addr", b.imem_addr, exp_q[0]);
                    end
                    pend_valid = 1;
                end
                if (b.instr_valid && b.instr_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL consume: got pc %h expected none", b.pc);
                    end else begin
                        p = exp_q.pop_front();
                        w = mem_word(p);
                        chk("pc", b.pc, p);
                        chk("instr", b.instr, w);
                        chk("opcode", {26'b0, b.opcode}, {26'b0, w[31:26]});
                        chk("pc_plus4", b.pc_plus4, p + 32'd4);
                        consumed++;
                    end
                end
            end else begin
                pend_valid = 0;
            end
        end
    end

    task automatic model_reset();
        exp_q.delete();
        cur_pc = 32'h0;
        exp_q.push_back(32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_req", {31'b0, b.imem_req}, 32'd0);
        chk("rst_valid", {31'b0, b.instr_valid}, 32'd0);
        chk("rst_instr", b.instr, 32'h0);
        chk("rst_pc", b.pc, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_held_pc(input logic [31:0] p, input int budget);
        bit hit;
        hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            if (b.instr_valid && b.pc == p) hit = 1;
        end
        if (!hit) begin
            tests++; fails++;
            $display("FAIL wait_held_pc: got timeout expected pc %h", p);
        end
    endtask

    initial begin : driver
        logic [31:0] i0, p0;
        bit          hit;
        rst_n = 1'b0;
        rst2_n = 1'b0;
        b2.imem_ack = 1'b0; b2.imem_rdata = 32'h0; b2.instr_ready = 1'b0;
        b2.branch = 1'b0; b2.zero = 1'b0; b2.branch_offset = 32'h0;
        model_reset();

        // Zero-wait memory, always ready
        ready_mode = 1; mem_wait = 0;
        do_reset();
        @(negedge clk); chk("t1_idle_req", {31'b0, b.imem_req}, 32'd0);
        @(negedge clk); chk("t1_req0", {31'b0, b.imem_req}, 32'd1); chk("t1_addr0", b.imem_addr, 32'h0);
        @(negedge clk); chk("t1_op0", {26'b0, b.opcode}, 32'h23); chk("t1_pp4_0", b.pc_plus4, 32'h4);
        @(negedge clk); chk("t1_req1", {31'b0, b.imem_req}, 32'd1); chk("t1_addr1", b.imem_addr, 32'h4);
        @(negedge clk); chk("t1_op1", {26'b0, b.opcode}, 32'h00); chk("t1_pp4_1", b.pc_plus4, 32'h8);

        // Three wait states
        mem_wait = 3;
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_req_held", {31'b0, b.imem_req}, 32'd1);
            chk("t2_addr_held", b.imem_addr, 32'h0);
            chk("t2_not_valid", {31'b0, b.instr_valid}, 32'd0);
        end
        @(negedge clk); chk("t2_valid", {31'b0, b.instr_valid}, 32'd1);

        // Taken and not-taken beq at pc 0x10
        mem_wait = 0; dir_en = 1; dir_pc = 32'h10; dir_off = 32'hFFFF_FFFC; dir_zero = 1;
        do_reset();
        wait_held_pc(32'h10, 60);
        @(negedge clk); chk("t3_taken_req", {31'b0, b.imem_req}, 32'd1); chk("t3_taken_addr", b.imem_addr, 32'h04);
        dir_zero = 0;
        do_reset();
        wait_held_pc(32'h10, 60);
        @(negedge clk); chk("t3_nt_req", {31'b0, b.imem_req}, 32'd1); chk("t3_nt_addr", b.imem_addr, 32'h14);
        dir_en = 0;

        // HOLD stall with toggling ack and branch
        ready_mode = 0; stray_en = 1;
        do_reset();
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            if (b.instr_valid) hit = 1;
        end
        chk("t4_reached_hold", {31'b0, hit}, 32'd1);
        i0 = mem_word(32'h0); p0 = 32'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_instr", b.instr, i0);
            chk("t4_pc", b.pc, p0);
            chk("t4_valid", {31'b0, b.instr_valid}, 32'd1);
            chk("t4_no_req", {31'b0, b.imem_req}, 32'd0);
        end
        ready_mode = 1;
        repeat (2) @(negedge clk);
        chk("t4_resume_req", {31'b0, b.imem_req}, 32'd1);
        chk("t4_resume_addr", b.imem_addr, 32'h4);
        stray_en = 0;

        // PC wrap-around on the second instance
        b2.imem_ack = 1'b1; b2.imem_rdata = 32'h2000_0000; b2.instr_ready = 1'b1;
        @(posedge clk); #1 rst2_n = 1'b1;
        @(negedge clk); chk("t5_idle_req", {31'b0, b2.imem_req}, 32'd0); chk("t5_rst_pc", b2.pc, 32'hFFFF_FFFC);
        @(negedge clk); chk("t5_req", {31'b0, b2.imem_req}, 32'd1); chk("t5_addr", b2.imem_addr, 32'hFFFF_FFFC);
        @(negedge clk); chk("t5_valid", {31'b0, b2.instr_valid}, 32'd1); chk("t5_pp4", b2.pc_plus4, 32'h0);
        @(negedge clk); chk("t5_wrap_req", {31'b0, b2.imem_req}, 32'd1); chk("t5_wrap_addr", b2.imem_addr, 32'h0);

        // Reset mid-FETCH at pc 0x20 with an ack during reset
        mem_wait = 20; ready_mode = 1;
        do_reset();
        hit = 0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk);
            if (b.imem_req && b.imem_addr == 32'h20) hit = 1;
        end
        chk("t6_reached_0x20", {31'b0, hit}, 32'd1);
        #2 rst_ack = 1; rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_req_drop", {31'b0, b.imem_req}, 32'd0);
        chk("t6_valid_drop", {31'b0, b.instr_valid}, 32'd0);
        mem_wait = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1; rst_ack = 0;
        @(negedge clk); chk("t6_idle_req", {31'b0, b.imem_req}, 32'd0);
        @(negedge clk); chk("t6_req", {31'b0, b.imem_req}, 32'd1); chk("t6_addr", b.imem_addr, 32'h0);
        @(negedge clk); chk("t6_instr", b.instr, 32'h8C01_0004);

        // Randomized traffic against the reference model
        ready_mode = 2; mem_rand = 1; stray_en = 1; rand_br = 1;
        do_reset();
        consumed = 0;
        repeat (1500) @(negedge clk);
        chk("rand_progress", {31'b0, consumed >= 100}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
